// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_pkg                                                      |
// | Shared word/memory geometry and arbiter state encodings.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_arbiter_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int MEM_DEPTH  = 1024;

    localparam logic [1:0] ARB_IDLE     = 2'd0;
    localparam logic [1:0] ARB_BUSY     = 2'd1;
    localparam logic [1:0] ARB_HANDOVER = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_rr_pick                                                  |
// | Combinational round-robin pick: first request at/after the pointer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arbiter_rr_pick #(
    parameter int N_REQ = 3,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic             any_req
);

    logic [N_REQ-1:0] w_hi_mask;
    logic [N_REQ-1:0] w_masked;
    logic [N_REQ-1:0] w_src;

    always_comb begin
        w_hi_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_hi_mask[i] = (IW'(i) >= ptr);
        end
    end

    // Prefer requests at or above the pointer; otherwise wrap to the lowest one.
    assign w_masked = req & w_hi_mask;
    assign w_src    = (|w_masked) ? w_masked : req;
    assign pick     = w_src & (-w_src);
    assign any_req  = |req;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter                                                          |
// | Round-robin, burst-limited arbiter sharing one single-port memory.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int AW        = WORD_WIDTH,
    parameter int DW        = WORD_WIDTH,
    parameter int MAX_BURST = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ-1:0]    req_wr_en,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [DW-1:0]       rdata,
    output logic [N_REQ-1:0]    rvalid,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_wr_en,
    output logic [DW-1:0]       mem_data_in,
    input  logic [DW-1:0]       mem_data_out
);

    localparam int              c_IW       = $clog2(N_REQ);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(N_REQ - 1);
    localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);
    localparam logic [7:0]      c_MAX      = 8'(MAX_BURST);
    localparam logic [7:0]      c_LIMIT    = 8'(MAX_BURST - 1);

    logic [1:0]       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_rvalid;
    logic [c_IW-1:0]  r_gidx;
    logic [c_IW-1:0]  r_ptr;
    logic [7:0]       r_burst;
    logic [AW-1:0]    r_addr_hold;
    logic [DW-1:0]    r_wdata_hold;

    logic [N_REQ-1:0] w_pick;
    logic             w_any_req;
    logic [c_IW-1:0]  w_pick_idx;
    logic             w_req_g;
    logic             w_wr_g;
    logic [AW-1:0]    w_addr_g;
    logic [DW-1:0]    w_wdata_g;
    logic             w_access;
    logic             w_others;
    logic             w_release;

    mem_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (c_IW)
    ) u_rr_pick (
        .req     (req),
        .ptr     (r_ptr),
        .pick    (w_pick),
        .any_req (w_any_req)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) w_pick_idx = c_IW'(i);
        end
    end

    // Grantee mux; with no grant the bus keeps its previous address/data.
    always_comb begin
        w_req_g   = 1'b0;
        w_wr_g    = 1'b0;
        w_addr_g  = r_addr_hold;
        w_wdata_g = r_wdata_hold;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                w_req_g   = req[i];
                w_wr_g    = req_wr_en[i];
                w_addr_g  = req_addr[i*AW +: AW];
                w_wdata_g = req_wdata[i*DW +: DW];
            end
        end
    end

    assign w_access  = (r_state == ARB_BUSY) && w_req_g;
    assign w_others  = |(req & ~r_gnt);
    assign w_release = !w_req_g || ((r_burst >= c_LIMIT) && w_others);

    assign gnt         = r_gnt;
    assign rvalid      = r_rvalid;
    assign rdata       = (|r_rvalid) ? mem_data_out : '0;
    assign mem_addr    = w_addr_g;
    assign mem_data_in = w_wdata_g;
    assign mem_wr_en   = w_access && w_wr_g;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_gnt        <= '0;
            r_rvalid     <= '0;
            r_gidx       <= '0;
            r_ptr        <= '0;
            r_burst      <= '0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            r_addr_hold  <= w_addr_g;
            r_wdata_hold <= w_wdata_g;
            r_rvalid     <= (w_access && !w_wr_g) ? r_gnt : '0;

            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_gnt   <= w_pick;
                        r_gidx  <= w_pick_idx;
                        r_burst <= '0;
                        r_state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_state <= ARB_HANDOVER;
                    end
                    // A lone requester keeps the grant; its count just saturates.
                    if (r_burst < c_MAX) r_burst <= r_burst + 8'd1;
                end
                ARB_HANDOVER: begin
                    r_ptr   <= (r_gidx == c_LAST_IDX) ? '0 : r_gidx + c_IDX_ONE;
                    r_burst <= '0;
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter                                                       |
// | Directed and random stimulus against a tenure-level reference model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MB = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_wr_en;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   rdata;
    logic [N-1:0]    rvalid;
    logic [AW-1:0]   mem_addr;
    logic            mem_wr_en;
    logic [DW-1:0]   mem_data_in;
    logic [DW-1:0]   mem_data_out;

    always #5 clock = ~clock;

    mem_arbiter #(
        .N_REQ     (N),
        .AW        (AW),
        .DW        (DW),
        .MAX_BURST (MB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_addr     (req_addr),
        .req_wr_en    (req_wr_en),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .mem_addr     (mem_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Synchronous single-port memory, read-before-write.
    logic [DW-1:0] mem [MEM_DEPTH];
    always @(posedge clock) begin
        if (mem_wr_en) mem[mem_addr[9:0]] <= mem_data_in;
        mem_data_out <= mem[mem_addr[9:0]];
    end

    logic          t_req  [N];
    logic          t_wr   [N];
    logic [AW-1:0] t_addr [N];
    logic [DW-1:0] t_wd   [N];

    // Reference model: who owns the memory, for how long, and the cool-down.
    int            m_owner;
    int            m_len;
    int            m_ptr;
    bit            m_cool;
    logic [N-1:0]  m_rv;
    logic [DW-1:0] m_rv_data;
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_last_wdata;
    logic [DW-1:0] ref_mem [MEM_DEPTH];

    int n_checks;
    int n_fail;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            req[k]                 = t_req[k];
            req_wr_en[k]           = t_wr[k];
            req_addr[k*AW +: AW]   = t_addr[k];
            req_wdata[k*DW +: DW]  = t_wd[k];
        end
    endtask

    task automatic set_req(input int k, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        t_req[k]  = r;
        t_wr[k]   = w;
        t_addr[k] = a;
        t_wd[k]   = d;
        apply();
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            t_req[k] = 1'b0;
            t_wr[k]  = 1'b0;
        end
        apply();
    endtask

    task automatic model_reset();
        m_owner      = -1;
        m_len        = 0;
        m_ptr        = 0;
        m_cool       = 1'b0;
        m_rv         = '0;
        m_rv_data    = '0;
        m_last_addr  = '0;
        m_last_wdata = '0;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    // Check one cycle against the model, advance the model, move to next negedge.
    task automatic tick();
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_rv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_wr;
        int            o;
        bit            others;
        #1;
        o      = m_owner;
        e_gnt  = '0;
        e_addr = m_last_addr;
        e_wd   = m_last_wdata;
        e_wr   = 1'b0;
        if (o >= 0) begin
            e_gnt[o] = 1'b1;
            e_addr   = t_addr[o];
            e_wd     = t_wd[o];
            e_wr     = t_req[o] && t_wr[o];
        end
        check_val("gnt", gnt, e_gnt);
        check_val("rvalid", rvalid, m_rv);
        check_val("rdata", rdata, (m_rv != '0) ? m_rv_data : '0);
        check_val("mem_wr_en", mem_wr_en, e_wr);
        check_val("mem_addr", mem_addr, e_addr);
        check_val("mem_data_in", mem_data_in, e_wd);

        e_rv = '0;
        if (o >= 0 && t_req[o]) begin
            if (t_wr[o]) ref_mem[t_addr[o][9:0]] = t_wd[o];
            else begin
                e_rv[o]   = 1'b1;
                m_rv_data = ref_mem[t_addr[o][9:0]];
            end
        end
        m_rv         = e_rv;
        m_last_addr  = e_addr;
        m_last_wdata = e_wd;

        if (reset) model_reset();
        else if (o >= 0) begin
            m_len++;
            others = 1'b0;
            for (int k = 0; k < N; k++) if (k != o && t_req[k]) others = 1'b1;
            if (!t_req[o] || (m_len >= MB && others)) begin
                m_ptr   = (o + 1) % N;
                m_owner = -1;
                m_cool  = 1'b1;
                m_len   = 0;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (m_owner < 0 && t_req[i]) begin
                    m_owner = i;
                    m_len   = 0;
                end
            end
        end
        @(negedge clock);
    endtask

    initial begin
        logic [DW-1:0] v3ff;
        logic [N-1:0]  hist [20];
        int            acc [N];
        int            order [$];
        int            starts [$];
        logic [N-1:0]  prev;
        int            s, r, run, drops;
        bit            done;

        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i]     = 16'(i * 37 + 5);
            ref_mem[i] = 16'(i * 37 + 5);
        end
        mem[16'h0010]     = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;
        v3ff = mem[10'h3FF];

        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            t_req[k] = 1'b0; t_wr[k] = 1'b0; t_addr[k] = '0; t_wd[k] = '0;
        end
        apply();
        repeat (2) @(negedge clock);
        model_reset();
        tick();
        #1;
        check_val("rst_gnt", gnt, 0);
        check_val("rst_rvalid", rvalid, 0);
        check_val("rst_addr", mem_addr, 0);

        // Single read from requester 1
        reset = 1'b0;
        set_req(1, 1'b1, 1'b0, 16'h0010, 16'h0);
        tick();
        #1;
        check_val("sr_gnt", gnt, 3'b010);
        check_val("sr_addr", mem_addr, 16'h0010);
        tick();
        set_req(1, 1'b0, 1'b0, 16'h0010, 16'h0);
        #1;
        check_val("sr_rvalid", rvalid, 3'b010);
        check_val("sr_rdata", rdata, 16'hBEEF);
        repeat (3) tick();

        // Write then readback in one burst
        set_req(0, 1'b1, 1'b1, 16'h0020, 16'h1234);
        tick();
        #1;
        check_val("wr_gnt", gnt, 3'b001);
        check_val("wr_en", mem_wr_en, 1);
        check_val("wr_data", mem_data_in, 16'h1234);
        tick();
        set_req(0, 1'b1, 1'b0, 16'h0020, 16'h0);
        #1;
        check_val("wr_en_off", mem_wr_en, 0);
        check_val("wr_no_rvalid", rvalid, 0);
        tick();
        set_req(0, 1'b0, 1'b0, 16'h0020, 16'h0);
        #1;
        check_val("rb_rvalid", rvalid, 3'b001);
        check_val("rb_rdata", rdata, 16'h1234);
        repeat (3) tick();

        // Contention from reset: each drops after two accesses
        reset = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, AW'(16'h0040 + k), 16'h0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < N; k++) acc[k] = 0;
        prev = '0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (gnt != '0 && prev == '0) begin
                order.push_back(onehot_idx(gnt));
                starts.push_back(c);
            end
            for (int k = 0; k < N; k++) if (gnt[k] && t_req[k]) acc[k]++;
            prev = gnt;
            tick();
            for (int k = 0; k < N; k++) if (acc[k] >= 2) t_req[k] = 1'b0;
            apply();
        end
        check_val("cont_n", order.size(), 3);
        for (int i = 0; i < order.size() && i < 3; i++) begin
            check_val("cont_order", order[i], i);
            if (i > 0) check_val("cont_gap", starts[i] - starts[i-1], 5);
        end

        // Burst limit: req0 held, req2 raised at its third access
        set_req(0, 1'b1, 1'b0, 16'h0050, 16'h0);
        acc[0] = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            hist[c] = gnt;
            if (gnt[0] && t_req[0]) acc[0]++;
            tick();
            if (acc[0] == 3) set_req(2, 1'b1, 1'b0, 16'h0052, 16'h0);
        end
        s = 0;
        while (s < 19 && hist[s] != 3'b001) s++;
        r = 0;
        while (s + r < 20 && hist[s + r] == 3'b001) r++;
        check_val("burst_len", r, MB);
        if (s + r + 2 < 20) begin
            check_val("burst_ho", hist[s + r], 0);
            check_val("burst_idle", hist[s + r + 1], 0);
            check_val("burst_next", hist[s + r + 2], 3'b100);
        end else check_val("burst_window", s + r + 2, 19);
        clear_all();
        repeat (6) tick();

        // Lone requester is never preempted
        set_req(0, 1'b1, 1'b0, 16'h0060, 16'h0);
        run = 0;
        drops = 0;
        for (int c = 0; c < 22; c++) begin
            #1;
            if (gnt == 3'b001) run++;
            else if (run > 0) drops++;
            tick();
        end
        check_val("lone_run", run, 21);
        check_val("lone_drops", drops, 0);
        clear_all();
        repeat (4) tick();

        // Reset during requester 1's fourth read
        set_req(1, 1'b1, 1'b0, 16'h0010, 16'h0);
        acc[1] = 0;
        done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (gnt[1] && t_req[1]) acc[1]++;
            if (acc[1] == 4) begin
                reset = 1'b1;
                tick();
                #1;
                check_val("mid_gnt", gnt, 0);
                check_val("mid_rvalid", rvalid, 0);
                done = 1'b1;
                break;
            end
            tick();
        end
        check_val("mid_done", done, 1);
        reset = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, AW'(16'h0070 + k), 16'h0);
        tick();
        #1;
        check_val("post_rst_gnt", gnt, 3'b001);

        // Ungranted requester 2 tries to write 0x03FF
        set_req(1, 1'b0, 1'b0, 16'h0071, 16'h0);
        set_req(2, 1'b1, 1'b1, 16'h03FF, 16'hDEAD);
        for (int c = 0; c < 6; c++) begin
            #1;
            check_val("iso_wr", mem_wr_en, 0);
            tick();
        end
        clear_all();
        repeat (5) tick();
        check_val("iso_mem", mem[10'h3FF], v3ff);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 9) == 0) t_req[k] = ~t_req[k];
                t_wr[k]   = ($urandom_range(0, 2) == 0);
                t_addr[k] = AW'($urandom_range(0, 63));
                t_wd[k]   = DW'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
            apply();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
